// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-word layout, interrupt-entry word and
// the interrupt-injection FSM state type.
package pipe_pkg;

   localparam int unsigned CTRL_W_DEF    = 40;
   localparam int unsigned CTRL_OPC_LSB  = 0;
   localparam int unsigned CTRL_OPC_W    = 8;
   localparam int unsigned CTRL_WB_BIT   = 38;
   localparam int unsigned CTRL_TRAP_BIT = 39;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PEND = 2'd1,
      INJ  = 2'd2
   } irq_state_e;

   function automatic logic [CTRL_W_DEF-1:0] ctrl_word(
      input logic                  trap,
      input logic                  wb,
      input logic [CTRL_OPC_W-1:0] opc
   );
      logic [CTRL_W_DEF-1:0] w;
      w = '0;
      w[CTRL_TRAP_BIT] = trap;
      w[CTRL_WB_BIT]   = wb;
      w[CTRL_OPC_LSB +: CTRL_OPC_W] = opc;
      return w;
   endfunction

   // Trap flag set, no writeback, opcode F1: jump to the interrupt vector.
   localparam logic [CTRL_W_DEF-1:0] IRQ_CTRL = ctrl_word(1'b1, 1'b0, 8'hF1);

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Instruction bus across one pipeline boundary: incoming stage fields and the
// registered copy presented to the next stage.
interface pipe_stage_reg_if #(
   parameter int unsigned CTRL_W  = pipe_pkg::CTRL_W_DEF,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned NUM_OPS = 2,
   parameter int unsigned PC_W    = 10,
   parameter int unsigned IR_W    = 18
);
   logic                             in_valid;
   logic [CTRL_W-1:0]                in_ctrl;
   logic [NUM_OPS-1:0][DATA_W-1:0]   in_ops;
   logic [PC_W-1:0]                  in_pc;
   logic [IR_W-1:0]                  in_ir;

   logic                             out_valid;
   logic [CTRL_W-1:0]                out_ctrl;
   logic [NUM_OPS-1:0][DATA_W-1:0]   out_ops;
   logic [PC_W-1:0]                  out_pc;
   logic [IR_W-1:0]                  out_ir;

   modport master (
      output in_valid, in_ctrl, in_ops, in_pc, in_ir,
      input  out_valid, out_ctrl, out_ops, out_pc, out_ir
   );

   modport slave (
      input  in_valid, in_ctrl, in_ops, in_pc, in_ir,
      output out_valid, out_ctrl, out_ops, out_pc, out_ir
   );
endinterface

// File: rtl/pipe_stage_reg_fsm.sv
// Interrupt-injection sequencer: latches a request, waits for a usable slot,
// then flags a one-cycle injection.
module irq_inject_fsm
   import pipe_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic irq_req,
   input  logic int_en,
   input  logic in_valid,
   input  logic stall,
   input  logic flush,
   output logic inject,
   output logic irq_ack,
   output logic irq_pending
);

   irq_state_e state;

   always_comb begin
      inject = (state == PEND) && int_en && in_valid && !stall && !flush;
   end

   // A stall without flush freezes the request capture too; INJ always lasts one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         irq_ack     <= 1'b0;
         irq_pending <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (irq_req && (flush || !stall)) begin
                  state       <= PEND;
                  irq_pending <= 1'b1;
               end
            end
            PEND: begin
               if (inject) begin
                  state       <= INJ;
                  irq_pending <= 1'b0;
                  irq_ack     <= 1'b1;
               end
            end
            INJ: begin
               state   <= RUN;
               irq_ack <= 1'b0;
            end
            default: begin
               state       <= RUN;
               irq_ack     <= 1'b0;
               irq_pending <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// One pipeline boundary register with stall, flush-to-bubble and interrupt
// injection in place of the incoming instruction.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       CTRL_W   = CTRL_W_DEF,
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       NUM_OPS  = 2,
   parameter int unsigned       PC_W     = 10,
   parameter int unsigned       IR_W     = 18,
   parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
   parameter logic [CTRL_W-1:0] CTRL_IRQ = CTRL_W'(IRQ_CTRL)
) (
   input  logic                   clk,
   input  logic                   rst,
   pipe_stage_reg_if.slave        bus,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   irq_req,
   input  logic                   int_en,
   output logic                   irq_ack,
   output logic                   irq_pending,
   output logic [15:0]            bubble_cnt
);

   logic inject;

   irq_inject_fsm u_fsm (
      .clk         (clk),
      .rst         (rst),
      .irq_req     (irq_req),
      .int_en      (int_en),
      .in_valid    (bus.in_valid),
      .stall       (stall),
      .flush       (flush),
      .inject      (inject),
      .irq_ack     (irq_ack),
      .irq_pending (irq_pending)
   );

   // Priority: flush, then injection, then stall, then plain load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.out_valid <= 1'b0;
         bus.out_ctrl  <= CTRL_NOP;
         bus.out_ops   <= '0;
         bus.out_pc    <= '0;
         bus.out_ir    <= '0;
         bubble_cnt    <= '0;
      end else if (flush) begin
         bus.out_valid <= 1'b0;
         bus.out_ctrl  <= CTRL_NOP;
         if (bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + 16'd1;
         end
      end else if (inject) begin
         bus.out_valid <= 1'b1;
         bus.out_ctrl  <= CTRL_IRQ;
         bus.out_ops   <= '0;
         bus.out_pc    <= bus.in_pc;
         bus.out_ir    <= bus.in_ir;
      end else if (!stall) begin
         bus.out_valid <= bus.in_valid;
         bus.out_ctrl  <= bus.in_ctrl;
         bus.out_ops   <= bus.in_ops;
         bus.out_pc    <= bus.in_pc;
         bus.out_ir    <= bus.in_ir;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, hand-written interrupt and
// reset sequences, randomized run against a reference model, saturation run.
module tb_pipe_stage_reg;

   localparam logic [39:0] NOP_W = 40'h0;
   localparam logic [39:0] IRQ_W = 40'h80_0000_00F1;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, irq_req, int_en;
   logic        irq_ack, irq_pending;
   logic [15:0] bubble_cnt;

   pipe_stage_reg_if #(.CTRL_W(40), .DATA_W(8), .NUM_OPS(2), .PC_W(10), .IR_W(18)) bus ();

   pipe_stage_reg #(.CTRL_W(40), .DATA_W(8), .NUM_OPS(2), .PC_W(10), .IR_W(18)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .stall       (stall),
      .flush       (flush),
      .irq_req     (irq_req),
      .int_en      (int_en),
      .irq_ack     (irq_ack),
      .irq_pending (irq_pending),
      .bubble_cnt  (bubble_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: what the next stage should see, plus whether a request
   // is waiting and whether an acknowledge is being shown this cycle.
   logic        m_valid;
   logic [39:0] m_ctrl;
   logic [15:0] m_ops;
   logic [9:0]  m_pc;
   logic [17:0] m_ir;
   logic        m_ack, m_pend;
   int unsigned m_cnt;

   typedef struct {
      logic        v, s, f, irq, ien;
      logic [39:0] ctrl;
      logic [9:0]  pc;
      logic        e_valid;
      logic [39:0] e_ctrl;
      logic [9:0]  e_pc;
      logic        e_ack, e_pend;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_ctrl = NOP_W; m_ops = '0; m_pc = '0; m_ir = '0;
      m_ack = 1'b0; m_pend = 1'b0; m_cnt = 0;
   endtask

   task automatic model_step();
      logic take, frozen;
      take   = m_pend && int_en && bus.in_valid && !stall && !flush;
      frozen = stall && !flush;
      if (flush) begin
         m_valid = 1'b0;
         m_ctrl  = NOP_W;
         m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end else if (take) begin
         m_valid = 1'b1; m_ctrl = IRQ_W; m_ops = '0;
         m_pc = bus.in_pc; m_ir = bus.in_ir;
      end else if (!stall) begin
         m_valid = bus.in_valid; m_ctrl = bus.in_ctrl; m_ops = bus.in_ops;
         m_pc = bus.in_pc; m_ir = bus.in_ir;
      end
      if (m_pend)     m_pend = !take;
      else if (m_ack) m_pend = 1'b0;
      else            m_pend = irq_req && !frozen;
      m_ack = take;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"},   {63'd0, bus.out_valid}, {63'd0, m_valid});
      chk({tag, ".ctrl"},    {24'd0, bus.out_ctrl},  {24'd0, m_ctrl});
      chk({tag, ".ops"},     {48'd0, bus.out_ops},   {48'd0, m_ops});
      chk({tag, ".pc"},      {54'd0, bus.out_pc},    {54'd0, m_pc});
      chk({tag, ".ir"},      {46'd0, bus.out_ir},    {46'd0, m_ir});
      chk({tag, ".ack"},     {63'd0, irq_ack},       {63'd0, m_ack});
      chk({tag, ".pending"}, {63'd0, irq_pending},   {63'd0, m_pend});
      chk({tag, ".bubbles"}, {48'd0, bubble_cnt},    {32'd0, m_cnt});
   endtask

   task automatic drive(input logic v, input logic [39:0] ctrl, input logic [15:0] ops,
                        input logic [9:0] pc, input logic [17:0] ir,
                        input logic s, input logic f, input logic irq, input logic ien);
      bus.in_valid = v; bus.in_ctrl = ctrl; bus.in_ops = ops;
      bus.in_pc = pc; bus.in_ir = ir;
      stall = s; flush = f; irq_req = irq; int_en = ien;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".valid"},   {63'd0, bus.out_valid}, 64'd0);
      chk({tag, ".ctrl"},    {24'd0, bus.out_ctrl},  {24'd0, NOP_W});
      chk({tag, ".ops"},     {48'd0, bus.out_ops},   64'd0);
      chk({tag, ".pc"},      {54'd0, bus.out_pc},    64'd0);
      chk({tag, ".ir"},      {46'd0, bus.out_ir},    64'd0);
      chk({tag, ".ack"},     {63'd0, irq_ack},       64'd0);
      chk({tag, ".pending"}, {63'd0, irq_pending},   64'd0);
      chk({tag, ".bubbles"}, {48'd0, bubble_cnt},    64'd0);
   endtask

   task automatic rnd_cycle(input logic s, input logic f, input logic irq, input logic ien,
                            input logic v, input logic [9:0] pc);
      drive(v, {8'd0, $urandom()}, 16'($urandom()), pc, 18'($urandom()), s, f, irq, ien);
      cycle();
   endtask

   initial begin
      drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b1;
      model_reset();

      // v s f irq ien ctrl pc -> valid ctrl pc ack pend cnt
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h1234, 10'h123, 1'b1, 40'h1234, 10'h123, 1'b0, 1'b0, 16'd0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 40'h5555, 10'h200, 1'b1, 40'h1234, 10'h123, 1'b0, 1'b0, 16'd0};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 40'h6666, 10'h201, 1'b0, NOP_W,    10'h123, 1'b0, 1'b0, 16'd1};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 40'h7777, 10'h202, 1'b0, 40'h7777, 10'h202, 1'b0, 1'b0, 16'd1};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 40'h11,   10'h010, 1'b1, 40'h11,   10'h010, 1'b0, 1'b1, 16'd1};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h12,   10'h011, 1'b1, 40'h12,   10'h011, 1'b0, 1'b1, 16'd1};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h13,   10'h2F0, 1'b1, IRQ_W,    10'h2F0, 1'b1, 1'b0, 16'd1};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 40'h14,   10'h2F1, 1'b1, 40'h14,   10'h2F1, 1'b0, 1'b0, 16'd1};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 40'h15,   10'h2F2, 1'b1, 40'h15,   10'h2F2, 1'b0, 1'b0, 16'd1};
      tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0,    10'h3FF, 1'b0, 40'h0,    10'h3FF, 1'b0, 1'b0, 16'd1};

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].v, tbl[i].ctrl, (i == 0) ? 16'h5AA5 : 16'($urandom()), tbl[i].pc,
               18'($urandom()), tbl[i].s, tbl[i].f, tbl[i].irq, tbl[i].ien);
         cycle();
         chk($sformatf("vec%0d.valid", i), {63'd0, bus.out_valid}, {63'd0, tbl[i].e_valid});
         chk($sformatf("vec%0d.ctrl", i),  {24'd0, bus.out_ctrl},  {24'd0, tbl[i].e_ctrl});
         chk($sformatf("vec%0d.pc", i),    {54'd0, bus.out_pc},    {54'd0, tbl[i].e_pc});
         chk($sformatf("vec%0d.ack", i),   {63'd0, irq_ack},       {63'd0, tbl[i].e_ack});
         chk($sformatf("vec%0d.pend", i),  {63'd0, irq_pending},   {63'd0, tbl[i].e_pend});
         chk($sformatf("vec%0d.cnt", i),   {48'd0, bubble_cnt},    {48'd0, tbl[i].e_cnt});
         if (i == 0) chk("vec0.ops", {48'd0, bus.out_ops}, 64'h5AA5);
         check_model($sformatf("vec%0d", i));
      end

      // Pending request held off by int_en, then taken with the return address.
      rnd_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h050);
      check_model("irq.latch");
      for (int i = 0; i < 4; i++) begin
         rnd_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h060);
         chk("irq.wait_pend", {63'd0, irq_pending}, 64'd1);
         chk("irq.wait_ack",  {63'd0, irq_ack},     64'd0);
      end
      rnd_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h061);
      chk("irq.stall_pend", {63'd0, irq_pending}, 64'd1);
      rnd_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h062);
      chk("irq.novalid_pend", {63'd0, irq_pending}, 64'd1);
      rnd_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h2F0);
      chk("irq.inj_ctrl", {24'd0, bus.out_ctrl}, {24'd0, IRQ_W});
      chk("irq.inj_pc",   {54'd0, bus.out_pc},   64'h2F0);
      chk("irq.inj_ops",  {48'd0, bus.out_ops},  64'd0);
      chk("irq.inj_ack",  {63'd0, irq_ack},      64'd1);
      chk("irq.inj_pend", {63'd0, irq_pending},  64'd0);
      check_model("irq.inj");
      rnd_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h2F1);
      chk("irq.ack_drop", {63'd0, irq_ack}, 64'd0);

      // Flush while pending defers injection by one edge.
      rnd_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h070);
      rnd_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'h071);
      chk("defer.valid", {63'd0, bus.out_valid}, 64'd0);
      chk("defer.pend",  {63'd0, irq_pending},   64'd1);
      chk("defer.ack",   {63'd0, irq_ack},       64'd0);
      check_model("defer.flush");
      rnd_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h072);
      chk("defer.inj_ctrl", {24'd0, bus.out_ctrl}, {24'd0, IRQ_W});
      chk("defer.inj_ack",  {63'd0, irq_ack},      64'd1);
      check_model("defer.inj");

      // Asynchronous reset while a request is pending.
      rnd_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h080);
      rnd_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h081);
      chk("rstmid.pend_before", {63'd0, irq_pending}, 64'd1);
      #2 rst = 1'b0;
      #1;
      check_zero("rstmid");
      model_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         rnd_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'(i + 5));
         chk("rstmid.no_ack", {63'd0, irq_ack}, 64'd0);
         check_model("rstmid.after");
      end

      // Randomized run against the reference model.
      for (int i = 0; i < 3000; i++) begin
         rnd_cycle(($urandom_range(3) == 0), ($urandom_range(9) == 0),
                   ($urandom_range(9) == 0), $urandom_range(1) != 0,
                   ($urandom_range(4) != 0), 10'($urandom()));
         check_model("rand");
      end

      // Saturation of the bubble counter from a clean reset.
      rst = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      for (int i = 1; i <= 65540; i++) begin
         rnd_cycle(($urandom_range(1) != 0), 1'b1, ($urandom_range(7) == 0),
                   $urandom_range(1) != 0, 1'b1, 10'($urandom()));
         if (i == 65534) chk("sat.fffe", {48'd0, bubble_cnt}, 64'hFFFE);
         if (i == 65535) chk("sat.ffff", {48'd0, bubble_cnt}, 64'hFFFF);
      end
      chk("sat.hold", {48'd0, bubble_cnt}, 64'hFFFF);
      check_model("sat");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameters: CTRL_W (default 40, control-word width); DATA_W (default 8, operand width); NUM_OPS (default 2, operand channels); PC_W (default 10); IR_W (default 18); CTRL_NOP (default all-zero, bubble word); CTRL_IRQ (default pipe_pkg::IRQ_CTRL, interrupt-entry word).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream stage holds a real instruction.
- in_ctrl  in  CTRL_W  decoded control word.
- in_ops  in  NUM_OPS x DATA_W  operand values.
- in_pc  in  PC_W  PC of incoming instruction.
- in_ir  in  IR_W  raw instruction.
- stall  in  1  hold all registered state.
- flush  in  1  replace the next output with a bubble.
- irq_req  in  1  interrupt request, level or pulse.
- int_en  in  1  interrupt enable flag.
- out_valid  out  1  registered valid.
- out_ctrl  out  CTRL_W  registered control word.
- out_ops  out  NUM_OPS x DATA_W  registered operands.
- out_pc  out  PC_W  registered PC (return address on injection).
- out_ir  out  IR_W  registered instruction.
- irq_ack  out  1  one-cycle pulse when injection is taken.
- irq_pending  out  1  request latched, not yet injected.
- bubble_cnt  out  16  saturating count of bubbles inserted.

Function
REQ-003 SHALL apply per-edge priority: flush > injection > stall > load.
REQ-004 SHALL, on load (no flush, no injection, stall=0), register every in_* to its out_* one cycle later.
REQ-005 SHALL, on stall=1 without flush, hold all out_*, FSM state and bubble_cnt.
REQ-006 SHALL, on flush=1, set out_valid=0 and out_ctrl=CTRL_NOP, hold out_ops/out_pc/out_ir, and increment bubble_cnt, even when stall=1.
REQ-007 SHALL run a 3-state FSM: RUN, PEND, INJ.
REQ-008 SHALL move RUN->PEND when irq_req=1; irq_req while in PEND or INJ is ignored (no queueing).
REQ-009 SHALL move PEND->INJ when int_en=1, in_valid=1, stall=0 and flush=0; otherwise it stays in PEND.
REQ-010 SHALL, on the PEND->INJ edge, register out_ctrl=CTRL_IRQ, out_valid=1, out_pc=in_pc (return address), out_ir=in_ir, and out_ops=0, and drop the incoming instruction.
REQ-011 SHALL assert irq_ack for exactly the cycle the FSM is in INJ, then return to RUN unconditionally.
REQ-012 SHALL drive irq_pending=1 exactly while the FSM is in PEND.
REQ-013 SHALL have bubble_cnt saturate at 16'hFFFF, with no wrap.
REQ-014 SHALL have zero latency from stall/flush to the next edge; no combinational path from any input to any output.

Reset
REQ-015 SHALL, on rst=0 at any time (including mid-PEND or INJ), immediately clear: out_valid=0, out_ctrl=CTRL_NOP, out_ops=0, out_pc=0, out_ir=0, irq_ack=0, irq_pending=0, bubble_cnt=0, FSM=RUN.
REQ-016 SHALL resume load behaviour on the first rising edge after rst deasserts; a pending interrupt is lost.

Structure
REQ-017 SHALL take IRQ_CTRL, the CTRL_W default, the state enum {RUN,PEND,INJ} and field-offset constants of the control word from shared package pipe_pkg.
REQ-018 SHALL place the FSM with irq_ack/irq_pending in sub-module irq_inject_fsm; the data path stays in pipe_stage_reg.
REQ-019 SHALL be instantiable per pipeline boundary, differing only by parameters.

Verification
REQ-020 Load: in_ctrl=0x00_0000_1234, in_ops={0x5A,0xA5}, in_pc=0x123, stall=flush=0 -> next cycle out_ctrl=0x1234, out_ops={0x5A,0xA5}, out_pc=0x123, out_valid=1.
REQ-021 Stall then flush: stall=1 for 3 cycles with changing inputs -> outputs frozen; then stall=1,flush=1 -> out_valid=0, out_ctrl=CTRL_NOP, bubble_cnt=1.
REQ-022 Interrupt: irq_req pulse with int_en=0 for 4 cycles -> irq_pending=1, no ack; then int_en=1, in_pc=0x2F0 -> next cycle out_ctrl=CTRL_IRQ, out_pc=0x2F0, irq_ack=1 for 1 cycle, irq_pending=0.
REQ-023 Interrupt deferral: PEND with flush=1 -> bubble issued, no injection; flush=0 -> injection on the following edge.
REQ-024 Reset mid-PEND: rst=0 asynchronously between edges -> all outputs zero at once, FSM=RUN, no irq_ack after release.
REQ-025 Saturation: 65,540 flush cycles -> bubble_cnt=0xFFFF and stays there.
